idex_pipe: RTL and testbench
============================

# idex_pipe

Parametrised ID/EX pipeline stage for the MIPS core. It sits between the decode stage and the execute stage, replacing the fixed-width, always-advancing ID/EX latch. Adds a valid/ready handshake with a 2-entry skid buffer, a synchronous flush for branch/exception squash, and optional load-use hazard detection that holds decode and inserts one bubble.

## Interface
Parameters:
- DATA_W, 32, width of DataA, DataB and imm_value
- REG_W, 5, width of the register specifiers RegRs, RegRt and RegRd
- WB_W, 2, width of the WB control bundle
- M_W, 3, width of the M control bundle
- EX_W, 4, width of the EX control bundle
- MEMREAD_BIT, 1, index of the memory-read flag inside M

Ports:
- clock  in  1  sole clock; everything updates on the rising edge
- reset  in  1  synchronous, active-high
- in_valid  in  1  decode presents a bundle
- in_ready  out  1  stage accepts the bundle this cycle
- flush  in  1  squash all held bundles
- WB, M, EX  in  WB_W/M_W/EX_W  control bundles
- DataA, DataB, imm_value  in  DATA_W  operands
- RegRs, RegRt, RegRd  in  REG_W  register specifiers
- out_valid  out  1  head bundle valid toward EX
- out_ready  in  1  EX consumes the head bundle
- WBreg, Mreg, EXreg, DataAreg, DataBreg, imm_valuereg, RegRsreg, RegRtreg, RegRdreg  out  same widths as the inputs  registered head bundle
- hazard_stall  out  1  load-use hold active; present only with IDEX_HAZARD_EN

## Operation
- Storage: a main register (head, drives the outputs) and a skid register. Each has a valid bit.
- States: EMPTY (no valid entries), ONE (main valid), FULL (main and skid valid).
- in_ready = !skid_valid && !hazard_stall. It has no combinational path from out_ready.
- Accept = in_valid && in_ready. Pop = out_valid && out_ready.
- EMPTY:
  - Accept: write main, go to ONE.
- ONE:
  - Accept and pop: write main, stay in ONE.
  - Accept without pop: write skid, go to FULL.
  - Pop without accept: go to EMPTY.
- FULL:
  - Pop: move skid to main, go to ONE.
  - No accept is possible in FULL.
- Ordering is FIFO. Bundles are never dropped or duplicated.
- Main and skid contents do not change while they are held and unpopped.
- flush: at the next edge both valid bits clear and WBreg, Mreg and EXreg go to 0. Data and specifier outputs hold their values. A bundle presented in the same cycle as flush is discarded, not accepted. Flush has priority over accept and pop.
- Load-use hazard (IDEX_HAZARD_EN only):
  - Youngest entry = skid if skid_valid, otherwise main.
  - hazard_stall = in_valid && youngest entry valid && youngest M[MEMREAD_BIT] && youngest Rt != 0 && (youngest Rt == RegRs || youngest Rt == RegRt).
  - hazard_stall is combinational.
  - The net effect is exactly one cycle with out_valid low between the load and its consumer.

## Timing
- Latency: a bundle accepted at edge N appears on the outputs after edge N when the stage was empty or popping. Otherwise it appears after the pop that promotes it.
- Throughput: one bundle per cycle while out_ready is held high.
- Reset: after the first edge with reset high, every output is 0 (out_valid, hazard_stall and all *reg buses), both valid bits are 0 and in_ready = 1.
- Reset overrides flush, accept and pop.
- Reset in the middle of a stall or while FULL discards all entries.
- flush and reset take effect at the edge where they are sampled. The stage can accept again in the following cycle.

## Configuration
- IDEX_HAZARD_EN defined: the hazard comparator and the hazard_stall port are compiled in, and in_ready includes the stall term.
- IDEX_HAZARD_EN undefined: no hazard_stall port and in_ready = !skid_valid. Hazards are resolved externally.

## Test plan
- Reset: hold reset for 2 cycles with in_valid = 1 -> all outputs are 0, in_ready = 1, and no bundle is accepted.
- Streaming: send 8 bundles with DataA = 1..8 and out_ready = 1 -> out_valid is high for 8 consecutive cycles and DataAreg = 1..8 in order, 1 cycle after each accept.
- Backpressure: hold out_ready = 0 while sending DataA = 10, 11, 12 -> 10 and 11 are accepted, in_ready drops to 0 and 12 is held by the source. Raising out_ready then yields 10, 11, 12 in order with no loss.
- Flush in FULL: flush with 2 entries held and a third bundle presented -> next cycle out_valid = 0, EXreg = Mreg = WBreg = 0, and the third bundle is absent from the output.
- Hazard (IDEX_HAZARD_EN):
  - Stimulus: a load with M = 3'b010 and RegRt = 5'd8 is held, and the next bundle has RegRs = 5'd8.
  - Required response: hazard_stall = 1 and in_ready = 0 until the load is popped. out_valid is 0 for exactly one cycle, then the consumer appears.
- Hazard with $zero: the same sequence with RegRt = 0 -> hazard_stall stays 0 and there is no bubble.

Source files
------------

// File: rtl/idex_pipe.sv
// rtl/idex_pipe.sv - ID/EX pipeline stage with 2-entry skid buffer, flush and optional load-use stall.
// Define IDEX_HAZARD_EN to compile in the load-use hazard comparator and the hazard_stall port.
module idex_pipe #(
  parameter int DATA_W      = 32,
  parameter int REG_W       = 5,
  parameter int WB_W        = 2,
  parameter int M_W         = 3,
  parameter int EX_W        = 4,
  parameter int MEMREAD_BIT = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              flush,
  input  logic [WB_W-1:0]   WB,
  input  logic [M_W-1:0]    M,
  input  logic [EX_W-1:0]   EX,
  input  logic [DATA_W-1:0] DataA,
  input  logic [DATA_W-1:0] DataB,
  input  logic [DATA_W-1:0] imm_value,
  input  logic [REG_W-1:0]  RegRs,
  input  logic [REG_W-1:0]  RegRt,
  input  logic [REG_W-1:0]  RegRd,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WB_W-1:0]   WBreg,
  output logic [M_W-1:0]    Mreg,
  output logic [EX_W-1:0]   EXreg,
  output logic [DATA_W-1:0] DataAreg,
  output logic [DATA_W-1:0] DataBreg,
  output logic [DATA_W-1:0] imm_valuereg,
  output logic [REG_W-1:0]  RegRsreg,
  output logic [REG_W-1:0]  RegRtreg,
`ifdef IDEX_HAZARD_EN
  output logic              hazard_stall,
`endif
  output logic [REG_W-1:0]  RegRdreg
);

  localparam int CTRL_W = WB_W + M_W + EX_W;
  localparam int BUN_W  = CTRL_W + 3 * DATA_W + 3 * REG_W;
  localparam int RT_LSB = REG_W;
  localparam int M_LSB  = EX_W + 3 * DATA_W + 3 * REG_W;

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

  state_t           state;
  logic [BUN_W-1:0] main_q;
  logic [BUN_W-1:0] skid_q;
  logic [BUN_W-1:0] in_bundle;
  logic             stall;
  logic             accept;
  logic             pop;

  // Bundles are packed control-first so a flush can clear the control field as one slice.
  assign in_bundle = {WB, M, EX, DataA, DataB, imm_value, RegRs, RegRt, RegRd};
  assign {WBreg, Mreg, EXreg, DataAreg, DataBreg, imm_valuereg,
          RegRsreg, RegRtreg, RegRdreg} = main_q;

  assign out_valid = (state != EMPTY);

`ifdef IDEX_HAZARD_EN
  logic             young_load;
  logic [REG_W-1:0] young_rt;

  // The youngest held bundle is the one the incoming consumer would directly follow.
  assign young_load = (state == FULL) ? skid_q[M_LSB + MEMREAD_BIT] : main_q[M_LSB + MEMREAD_BIT];
  assign young_rt   = (state == FULL) ? skid_q[RT_LSB +: REG_W] : main_q[RT_LSB +: REG_W];
  assign stall = in_valid && out_valid && young_load && (young_rt != '0) &&
                 ((young_rt == RegRs) || (young_rt == RegRt));
  assign hazard_stall = stall;
`else
  assign stall = 1'b0;
`endif

  assign in_ready = (state != FULL) && !stall;
  assign accept   = in_valid && in_ready;
  assign pop      = out_valid && out_ready;

  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= EMPTY;
      main_q <= '0;
      skid_q <= '0;
    end else if (flush) begin
      // Data and specifiers hold; only control is zeroed so a squashed bundle cannot write back.
      state                        <= EMPTY;
      main_q[BUN_W-1 -: CTRL_W]    <= '0;
      skid_q[BUN_W-1 -: CTRL_W]    <= '0;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            main_q <= in_bundle;
            state  <= ONE;
          end
        end
        ONE: begin
          if (accept && pop) begin
            main_q <= in_bundle;
          end else if (accept) begin
            skid_q <= in_bundle;
            state  <= FULL;
          end else if (pop) begin
            state  <= EMPTY;
          end
        end
        FULL: begin
          if (pop) begin
            main_q <= skid_q;
            state  <= ONE;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_idex_pipe.sv
// tb/tb_idex_pipe.sv - self-checking bench for idex_pipe: vector table, hand sequences, random vs queue model.
module tb_idex_pipe;

  logic         clock = 1'b0;
  logic         reset, in_valid, flush, out_ready;
  logic [1:0]   WB;
  logic [2:0]   M;
  logic [3:0]   EX;
  logic [31:0]  DataA, DataB, imm_value;
  logic [4:0]   RegRs, RegRt, RegRd;
  logic         in_ready, out_valid;
  logic [1:0]   WBreg;
  logic [2:0]   Mreg;
  logic [3:0]   EXreg;
  logic [31:0]  DataAreg, DataBreg, imm_valuereg;
  logic [4:0]   RegRsreg, RegRtreg, RegRdreg;
`ifdef IDEX_HAZARD_EN
  logic         hazard_stall;
`endif

  int total = 0;
  int bad   = 0;

  wire [119:0] in_bus  = {WB, M, EX, DataA, DataB, imm_value, RegRs, RegRt, RegRd};
  wire [119:0] out_bus = {WBreg, Mreg, EXreg, DataAreg, DataBreg, imm_valuereg,
                          RegRsreg, RegRtreg, RegRdreg};
  wire [8:0]   out_ctrl = {WBreg, Mreg, EXreg};

  idex_pipe dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .flush(flush),
    .WB(WB), .M(M), .EX(EX), .DataA(DataA), .DataB(DataB), .imm_value(imm_value),
    .RegRs(RegRs), .RegRt(RegRt), .RegRd(RegRd),
    .out_valid(out_valid), .out_ready(out_ready),
    .WBreg(WBreg), .Mreg(Mreg), .EXreg(EXreg), .DataAreg(DataAreg), .DataBreg(DataBreg),
    .imm_valuereg(imm_valuereg), .RegRsreg(RegRsreg), .RegRtreg(RegRtreg),
`ifdef IDEX_HAZARD_EN
    .hazard_stall(hazard_stall),
`endif
    .RegRdreg(RegRdreg)
  );

  always #5 clock = ~clock;

  task automatic chk1(input string nm, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0b want %0b", nm, act, exp);
    end
  endtask

  task automatic chkw(input string nm, input logic [119:0] act, input logic [119:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive_bus(input logic [119:0] b);
    {WB, M, EX, DataA, DataB, imm_value, RegRs, RegRt, RegRd} = b;
  endtask

  task automatic pulse_reset();
    reset = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  typedef struct {
    logic        iv, ordy, fl;
    logic [31:0] a;
    logic        e_ov, e_ir;
    logic [31:0] e_a;
    logic [8:0]  e_ctrl;
  } vec_t;

  vec_t tbl[21];
  localparam logic [8:0] C = 9'h19F;

  logic [119:0] q[$];
  logic [127:0] r;
  logic [119:0] y;
  logic         exp_stall, exp_ready, acc, pp;

  initial begin
    for (int k = 0; k < 8; k++)
      tbl[k] = '{1'b1, 1'b1, 1'b0, 32'(k + 1), 1'b1, 1'b1, 32'(k + 1), C};
    tbl[8]  = '{1'b0, 1'b1, 1'b0, 32'd0,  1'b0, 1'b1, 32'd8,  C};
    tbl[9]  = '{1'b1, 1'b0, 1'b0, 32'd10, 1'b1, 1'b1, 32'd10, C};
    tbl[10] = '{1'b1, 1'b0, 1'b0, 32'd11, 1'b1, 1'b0, 32'd10, C};
    tbl[11] = '{1'b1, 1'b0, 1'b0, 32'd12, 1'b1, 1'b0, 32'd10, C};
    tbl[12] = '{1'b1, 1'b1, 1'b0, 32'd12, 1'b1, 1'b1, 32'd11, C};
    tbl[13] = '{1'b1, 1'b1, 1'b0, 32'd12, 1'b1, 1'b1, 32'd12, C};
    tbl[14] = '{1'b0, 1'b1, 1'b0, 32'd0,  1'b0, 1'b1, 32'd12, C};
    tbl[15] = '{1'b1, 1'b0, 1'b0, 32'd20, 1'b1, 1'b1, 32'd20, C};
    tbl[16] = '{1'b1, 1'b0, 1'b0, 32'd21, 1'b1, 1'b0, 32'd20, C};
    tbl[17] = '{1'b1, 1'b0, 1'b1, 32'd22, 1'b0, 1'b1, 32'd20, 9'h000};
    tbl[18] = '{1'b0, 1'b1, 1'b0, 32'd0,  1'b0, 1'b1, 32'd20, 9'h000};
    tbl[19] = '{1'b1, 1'b1, 1'b0, 32'd30, 1'b1, 1'b1, 32'd30, C};
    tbl[20] = '{1'b0, 1'b1, 1'b0, 32'd0,  1'b0, 1'b1, 32'd30, C};

    // Reset held two cycles with a bundle presented.
    reset = 1'b1; in_valid = 1'b1; flush = 1'b0; out_ready = 1'b0;
    drive_bus({2'b11, 3'b111, 4'hF, 32'd99, 32'd98, 32'd97, 5'd1, 5'd2, 5'd3});
    for (int i = 0; i < 2; i++) begin
      tick();
      chkw("reset_outputs", out_bus, '0);
      chk1("reset_out_valid", out_valid, 1'b0);
      chk1("reset_in_ready", in_ready, 1'b1);
`ifdef IDEX_HAZARD_EN
      chk1("reset_hazard_stall", hazard_stall, 1'b0);
`endif
    end
    reset = 1'b0; in_valid = 1'b0;
    tick();
    chk1("reset_nothing_accepted", out_valid, 1'b0);

    // Streaming, backpressure and flush-in-FULL vectors.
    for (int i = 0; i < 21; i++) begin
      in_valid = tbl[i].iv; out_ready = tbl[i].ordy; flush = tbl[i].fl;
      drive_bus({2'b11, 3'b001, 4'hF, tbl[i].a, 32'h55, 32'h66, 5'd1, 5'd2, 5'd3});
      tick();
      chk1($sformatf("vec%0d_out_valid", i), out_valid, tbl[i].e_ov);
      chk1($sformatf("vec%0d_in_ready", i), in_ready, tbl[i].e_ir);
      chkw($sformatf("vec%0d_DataAreg", i), 120'(DataAreg), 120'(tbl[i].e_a));
      chkw($sformatf("vec%0d_ctrl", i), 120'(out_ctrl), 120'(tbl[i].e_ctrl));
    end
    flush = 1'b0;

    // Reset while FULL discards both entries.
    in_valid = 1'b1; out_ready = 1'b0;
    tick();
    tick();
    chk1("full_before_reset_in_ready", in_ready, 1'b0);
    reset = 1'b1;
    tick();
    chk1("full_reset_out_valid", out_valid, 1'b0);
    chk1("full_reset_in_ready", in_ready, 1'b1);
    chkw("full_reset_outputs", out_bus, '0);
    reset = 1'b0; in_valid = 1'b0;
    tick();

`ifdef IDEX_HAZARD_EN
    // Load followed by a dependent consumer: one bubble.
    pulse_reset();
    in_valid = 1'b1; out_ready = 1'b0;
    drive_bus({2'b01, 3'b010, 4'h1, 32'd100, 32'd0, 32'd0, 5'd1, 5'd8, 5'd0});
    tick();
    drive_bus({2'b01, 3'b000, 4'h2, 32'd101, 32'd0, 32'd0, 5'd8, 5'd3, 5'd4});
    #1;
    chk1("hz_stall_held", hazard_stall, 1'b1);
    chk1("hz_in_ready_held", in_ready, 1'b0);
    tick();
    chk1("hz_stall_still", hazard_stall, 1'b1);
    chkw("hz_load_head", 120'(DataAreg), 120'(32'd100));
    out_ready = 1'b1;
    #1;
    chk1("hz_stall_popping", hazard_stall, 1'b1);
    tick();
    chk1("hz_bubble", out_valid, 1'b0);
    chk1("hz_stall_released", hazard_stall, 1'b0);
    chk1("hz_in_ready_released", in_ready, 1'b1);
    tick();
    chk1("hz_consumer_valid", out_valid, 1'b1);
    chkw("hz_consumer_data", 120'(DataAreg), 120'(32'd101));
    in_valid = 1'b0;
    tick();

    // Same with $zero as the load target: no stall, no bubble.
    pulse_reset();
    in_valid = 1'b1; out_ready = 1'b1;
    drive_bus({2'b01, 3'b010, 4'h1, 32'd100, 32'd0, 32'd0, 5'd1, 5'd0, 5'd0});
    tick();
    drive_bus({2'b01, 3'b000, 4'h2, 32'd101, 32'd0, 32'd0, 5'd0, 5'd0, 5'd4});
    #1;
    chk1("hz0_no_stall", hazard_stall, 1'b0);
    chk1("hz0_in_ready", in_ready, 1'b1);
    tick();
    chk1("hz0_no_bubble", out_valid, 1'b1);
    chkw("hz0_consumer_data", 120'(DataAreg), 120'(32'd101));
    in_valid = 1'b0;
    tick();
`endif

    // Random traffic against a FIFO-of-bundles reference model.
    pulse_reset();
    q.delete();
    for (int c = 0; c < 600; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 24) == 0);
      r = {$urandom(), $urandom(), $urandom(), $urandom()};
      drive_bus(r[119:0]);
      RegRs = 5'($urandom_range(0, 3));
      RegRt = 5'($urandom_range(0, 3));
      #1;
      exp_stall = 1'b0;
`ifdef IDEX_HAZARD_EN
      if (q.size() > 0) begin
        y = q[q.size() - 1];
        exp_stall = in_valid && y[116] && (y[9:5] != 5'd0) &&
                    ((y[9:5] == RegRs) || (y[9:5] == RegRt));
      end
      chk1("rnd_hazard_stall", hazard_stall, exp_stall);
`endif
      exp_ready = (q.size() < 2) && !exp_stall;
      chk1("rnd_in_ready", in_ready, exp_ready);
      chk1("rnd_out_valid", out_valid, q.size() > 0);
      if (q.size() > 0) chkw("rnd_head", out_bus, q[0]);
      acc = in_valid && exp_ready;
      pp  = (q.size() > 0) && out_ready;
      if (flush) q.delete();
      else begin
        if (pp) void'(q.pop_front());
        if (acc) q.push_back(in_bus);
      end
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
